// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// A slot describes one instruction in flight in the back-end (EX..WB).
package pipe_ctrl_pkg;

  // Slot numbering: slot 1 is EX, slot 2 is MEM, the last slot is WB.
  localparam int SLOT_EX  = 1;
  localparam int SLOT_MEM = 2;

  // Operand-mux select meaning "take the ID/EX register data".
  localparam int FWD_NONE = 0;

  // Slot fields are sized for the widest supported configuration:
  // register addresses up to 8 bits, slot indices up to 8 (NB <= 8).
  localparam int SLOT_AW = 8;
  localparam int SLOT_IW = 4;

  // One in-flight instruction. rs1/rs2 are stored as 0 when the operand
  // is not read, and wr is already cleared for rd == x0, so a plain
  // equality test against a nonzero source is a complete match rule.
  typedef struct packed {
    logic               valid;
    logic               wr;
    logic [SLOT_AW-1:0] rd;
    logic [SLOT_AW-1:0] rs1;
    logic [SLOT_AW-1:0] rs2;
    logic [SLOT_IW-1:0] rdy;   // slot index after which the result is forwardable
  } slot_t;

  // What the back-end does this cycle, in priority order.
  typedef enum logic [1:0] {
    ACT_ISSUE    = 2'd0,
    ACT_HAZARD   = 2'd1,
    ACT_REDIRECT = 2'd2,
    ACT_FREEZE   = 2'd3
  } act_e;

  // True when slot s holds a tracked writer of nonzero register rs.
  function automatic logic slot_writes(input slot_t s, input logic [SLOT_AW-1:0] rs);
    return s.valid && s.wr && (rs != '0) && (s.rd == rs);
  endfunction

endpackage

// File: rtl/pipe_slot_match.sv
// Priority encoder over a contiguous range of back-end slots: finds the
// youngest (lowest-numbered) slot in LO..HI that writes register rs_i and
// reports its index and ready point.
module pipe_slot_match
  import pipe_ctrl_pkg::*;
#(
  parameter int NB = 3,
  parameter int LO = 1,
  parameter int HI = 2
) (
  input  logic [SLOT_AW-1:0] rs_i,
  input  slot_t [NB:1]       slots_i,
  output logic               hit_o,
  output logic [SLOT_IW-1:0] idx_o,
  output logic [SLOT_IW-1:0] rdy_o
);

  // Only valid/wr/rd/rdy matter here; the source fields ride along in the
  // same packed vector and are folded away.
  logic unused_fields;
  assign unused_fields = ^slots_i;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    rdy_o = '0;
    for (int k = HI; k >= LO; k--) begin
      if (slot_writes(slots_i[k], rs_i)) begin
        hit_o = 1'b1;
        idx_o = SLOT_IW'(k);
        rdy_o = slots_i[k].rdy;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order back-end (EX..WB).
// Keeps a shift register of in-flight instructions, stalls ID when a
// source is produced by a not-yet-forwardable writer, freezes on mem_wait,
// squashes ID on a redirect, and selects EX operand forwarding sources.
// Legal configurations: 3 <= NB <= 8, 1+LOAD_LAT <= NB-1, REG_AW <= 8.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NB       = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [REG_AW-1:0]       id_rs1,
  input  logic                    id_rs1_used,
  input  logic [REG_AW-1:0]       id_rs2,
  input  logic                    id_rs2_used,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic                    id_reg_write,
  input  logic                    id_is_load,
  input  logic                    ex_redirect,
  input  logic                    mem_wait,
  output logic                    stall_id,
  output logic                    bubble_ex,
  output logic                    flush_if_id,
  output logic                    freeze,
  output logic [$clog2(NB)-1:0]   fwd_sel_a,
  output logic [$clog2(NB)-1:0]   fwd_sel_b,
  output logic [$clog2(NB):0]     inflight_cnt
);

  localparam int SW = $clog2(NB);

  slot_t [NB:1] slot_q;
  slot_t [NB:1] slot_d;
  slot_t        id_slot;
  act_e         act;

  logic [SLOT_AW-1:0] id_rs1_x, id_rs2_x, id_rd_x;
  logic [SLOT_AW-1:0] ex_rs1, ex_rs2;

  logic               h1_hit, h2_hit, fa_hit, fb_hit;
  logic [SLOT_IW-1:0] h1_idx, h2_idx, fa_idx, fb_idx;
  logic [SLOT_IW-1:0] h1_rdy, h2_rdy;
  logic [SLOT_IW-1:0] fa_rdy_unused, fb_rdy_unused;
  logic [SLOT_IW-1:0] fa_idx_m1, fb_idx_m1;
  logic               hazard;
  logic [SW:0]        cnt_w;

  // Widen ID register addresses to the slot field width.
  assign id_rs1_x = SLOT_AW'(id_rs1);
  assign id_rs2_x = SLOT_AW'(id_rs2);
  assign id_rd_x  = SLOT_AW'(id_rd);

  // Slot image of the instruction currently in ID, built for issue.
  always_comb begin
    id_slot       = '0;
    id_slot.valid = 1'b1;
    id_slot.wr    = id_reg_write && (id_rd != '0);
    id_slot.rd    = id_rd_x;
    id_slot.rs1   = id_rs1_used ? id_rs1_x : '0;
    id_slot.rs2   = id_rs2_used ? id_rs2_x : '0;
    id_slot.rdy   = id_is_load ? SLOT_IW'(SLOT_EX + LOAD_LAT) : SLOT_IW'(SLOT_EX);
  end

  // Load-use hazard search: youngest writer among slots EX..NB-1. The WB
  // slot is excluded because the register file is write-first.
  pipe_slot_match #(.NB(NB), .LO(SLOT_EX), .HI(NB-1)) u_haz_rs1 (
    .rs_i    (id_slot.rs1),
    .slots_i (slot_q),
    .hit_o   (h1_hit),
    .idx_o   (h1_idx),
    .rdy_o   (h1_rdy)
  );

  pipe_slot_match #(.NB(NB), .LO(SLOT_EX), .HI(NB-1)) u_haz_rs2 (
    .rs_i    (id_slot.rs2),
    .slots_i (slot_q),
    .hit_o   (h2_hit),
    .idx_o   (h2_idx),
    .rdy_o   (h2_rdy)
  );

  // A match stalls only while the writer has not yet reached its ready slot.
  assign hazard = id_valid &&
                  ((h1_hit && (h1_idx < h1_rdy)) || (h2_hit && (h2_idx < h2_rdy)));

  // Forwarding for the instruction in EX: youngest writer in MEM..WB.
  // Sources come only from registered slot state, never from ID inputs.
  assign ex_rs1 = slot_q[SLOT_EX].valid ? slot_q[SLOT_EX].rs1 : '0;
  assign ex_rs2 = slot_q[SLOT_EX].valid ? slot_q[SLOT_EX].rs2 : '0;

  pipe_slot_match #(.NB(NB), .LO(SLOT_MEM), .HI(NB)) u_fwd_a (
    .rs_i    (ex_rs1),
    .slots_i (slot_q),
    .hit_o   (fa_hit),
    .idx_o   (fa_idx),
    .rdy_o   (fa_rdy_unused)
  );

  pipe_slot_match #(.NB(NB), .LO(SLOT_MEM), .HI(NB)) u_fwd_b (
    .rs_i    (ex_rs2),
    .slots_i (slot_q),
    .hit_o   (fb_hit),
    .idx_o   (fb_idx),
    .rdy_o   (fb_rdy_unused)
  );

  // Select j-1 means "pipeline register after slot j-1", i.e. the register
  // that currently holds slot j's result.
  assign fa_idx_m1 = fa_idx - SLOT_IW'(1);
  assign fb_idx_m1 = fb_idx - SLOT_IW'(1);
  assign fwd_sel_a = fa_hit ? fa_idx_m1[SW-1:0] : SW'(FWD_NONE);
  assign fwd_sel_b = fb_hit ? fb_idx_m1[SW-1:0] : SW'(FWD_NONE);

  // Resolve this cycle's action: mem_wait beats redirect beats hazard.
  always_comb begin
    act = ACT_ISSUE;
    if (mem_wait) begin
      act = ACT_FREEZE;
    end else if (ex_redirect) begin
      act = ACT_REDIRECT;
    end else if (hazard) begin
      act = ACT_HAZARD;
    end
  end

  // Control outputs are forced low while reset is asserted.
  assign freeze      = !reset && (act == ACT_FREEZE);
  assign stall_id    = !reset && ((act == ACT_FREEZE) || (act == ACT_HAZARD));
  assign bubble_ex   = !reset && ((act == ACT_REDIRECT) || (act == ACT_HAZARD));
  assign flush_if_id = !reset && (act == ACT_REDIRECT);

  // Slot shift register: hold on freeze, otherwise shift toward WB and load
  // EX with either the ID instruction or a bubble.
  always_comb begin
    slot_d = slot_q;
    if (act != ACT_FREEZE) begin
      for (int k = NB; k >= 2; k--) begin
        slot_d[k] = slot_q[k-1];
      end
      slot_d[SLOT_EX] = '0;
      if ((act == ACT_ISSUE) && id_valid) begin
        slot_d[SLOT_EX] = id_slot;
      end
    end
  end

  // Slot state register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Count tracked writers across all back-end slots.
  always_comb begin
    cnt_w = '0;
    for (int k = 1; k <= NB; k++) begin
      cnt_w = cnt_w + {{SW{1'b0}}, (slot_q[k].valid && slot_q[k].wr)};
    end
  end

  assign inflight_cnt = cnt_w;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations (NB=3/LOAD_LAT=1 and
// NB=4/LOAD_LAT=2) share one stimulus stream. A behavioural model tracks
// the instructions in flight as a list ordered by age and derives every
// output from the stall/forward rules; directed sequences pin the model
// with literal expectations before a randomized run.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect, mem_wait;

  logic       st[2], bub[2], fl[2], fz[2];
  logic [1:0] fa[2], fb[2];
  logic [2:0] cnt[2];

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .NB(3), .LOAD_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .mem_wait(mem_wait),
    .stall_id(st[0]), .bubble_ex(bub[0]), .flush_if_id(fl[0]), .freeze(fz[0]),
    .fwd_sel_a(fa[0]), .fwd_sel_b(fb[0]), .inflight_cnt(cnt[0])
  );

  pipe_hazard_ctrl #(.REG_AW(5), .NB(4), .LOAD_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .mem_wait(mem_wait),
    .stall_id(st[1]), .bubble_ex(bub[1]), .flush_if_id(fl[1]), .freeze(fz[1]),
    .fwd_sel_a(fa[1]), .fwd_sel_b(fb[1]), .inflight_cnt(cnt[1])
  );

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic       v;
    logic       w;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_t;

  typedef struct packed {
    logic       st, bub, fl, fz;
    logic [3:0] fa, fb, cnt;
  } exp_t;

  // pos 1 = EX (youngest) ... pos nb = WB (oldest)
  instr_t pipe_m [2][1:8];

  function automatic int nb_of(input int m);
    return (m == 0) ? 3 : 4;
  endfunction

  function automatic int ll_of(input int m);
    return (m == 0) ? 1 : 2;
  endfunction

  function automatic bit is_writer(input instr_t s, input logic [4:0] r);
    return s.v && s.w && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  // Does ID source r have to wait? Youngest writer before WB decides.
  function automatic bit rs_waits(input int m, input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int p = 1; p <= nb_of(m) - 1; p++) begin
      if (is_writer(pipe_m[m][p], r)) begin
        return p < (pipe_m[m][p].ld ? 1 + ll_of(m) : 1);
      end
    end
    return 1'b0;
  endfunction

  function automatic bit id_stalls(input int m);
    return id_valid && ((id_rs1_used && rs_waits(m, id_rs1)) ||
                        (id_rs2_used && rs_waits(m, id_rs2)));
  endfunction

  // Forward source for the EX instruction's operand r.
  function automatic int fwd_of(input int m, input logic [4:0] r);
    if (!pipe_m[m][1].v || r == 5'd0) return 0;
    for (int p = 2; p <= nb_of(m); p++) begin
      if (is_writer(pipe_m[m][p], r)) return p - 1;
    end
    return 0;
  endfunction

  function automatic exp_t expect_of(input int m);
    exp_t e;
    int   n;
    e = '0;
    if (reset) return e;
    if (mem_wait) begin
      e.fz = 1'b1;
      e.st = 1'b1;
    end else if (ex_redirect) begin
      e.fl  = 1'b1;
      e.bub = 1'b1;
    end else if (id_stalls(m)) begin
      e.st  = 1'b1;
      e.bub = 1'b1;
    end
    e.fa = 4'(fwd_of(m, pipe_m[m][1].rs1));
    e.fb = 4'(fwd_of(m, pipe_m[m][1].rs2));
    n = 0;
    for (int p = 1; p <= nb_of(m); p++) begin
      if (pipe_m[m][p].v && pipe_m[m][p].w && pipe_m[m][p].rd != 5'd0) n++;
    end
    e.cnt = 4'(n);
    return e;
  endfunction

  task automatic model_step(input int m);
    bit     hz;
    instr_t n;
    hz = id_stalls(m);
    if (mem_wait) return;
    for (int p = nb_of(m); p >= 2; p--) pipe_m[m][p] = pipe_m[m][p-1];
    n = '0;
    if (!ex_redirect && !hz && id_valid) begin
      n.v   = 1'b1;
      n.w   = id_reg_write;
      n.ld  = id_is_load;
      n.rd  = id_rd;
      n.rs1 = id_rs1_used ? id_rs1 : 5'd0;
      n.rs2 = id_rs2_used ? id_rs2 : 5'd0;
    end
    pipe_m[m][1] = n;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++)
        for (int p = 1; p <= 8; p++) pipe_m[m][p] = '0;
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, both DUTs against the model, away from the rising edge.
  bit compare_on = 1'b0;
  always @(negedge clk) begin
    if (compare_on) begin
      for (int m = 0; m < 2; m++) begin
        exp_t e;
        e = expect_of(m);
        check($sformatf("dut%0d_stall_id", m),    32'(st[m]),  32'(e.st));
        check($sformatf("dut%0d_bubble_ex", m),   32'(bub[m]), 32'(e.bub));
        check($sformatf("dut%0d_flush_if_id", m), 32'(fl[m]),  32'(e.fl));
        check($sformatf("dut%0d_freeze", m),      32'(fz[m]),  32'(e.fz));
        check($sformatf("dut%0d_fwd_sel_a", m),   32'(fa[m]),  32'(e.fa));
        check($sformatf("dut%0d_fwd_sel_b", m),   32'(fb[m]),  32'(e.fb));
        check($sformatf("dut%0d_inflight", m),    32'(cnt[m]), 32'(e.cnt));
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rd, input bit wr, input bit ld,
                        input int rs1, input bit u1, input int rs2, input bit u2);
    id_valid     = v;
    id_rd        = 5'(rd);
    id_reg_write = wr;
    id_is_load   = ld;
    id_rs1       = 5'(rs1);
    id_rs1_used  = u1;
    id_rs2       = 5'(rs2);
    id_rs2_used  = u2;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (5) tick();
  endtask

  initial begin
    for (int m = 0; m < 2; m++)
      for (int p = 1; p <= 8; p++) pipe_m[m][p] = '0;
    reset       = 1'b1;
    ex_redirect = 1'b0;
    mem_wait    = 1'b0;
    idle();
    compare_on  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #2;
    check("reset_stall",  32'(st[0]),  32'd0);
    check("reset_freeze", 32'(fz[0]),  32'd0);
    check("reset_fwd_a",  32'(fa[0]),  32'd0);
    check("reset_cnt",    32'(cnt[1]), 32'd0);
    tick();

    // ALU to ALU: no stall, forward from MEM.
    set_id(1, 1, 1, 0, 3, 1, 4, 1);
    #2 check("alu_first_stall", 32'(st[0]), 32'd0);
    tick();
    set_id(1, 2, 1, 0, 1, 1, 3, 1);
    #2 check("alu_use_stall", 32'(st[0]), 32'd0);
    tick();
    idle();
    #2 check("alu_fwd_a", 32'(fa[0]), 32'd1);
    check("alu_fwd_b", 32'(fb[0]), 32'd0);
    drain();

    // Load-use with LOAD_LAT=1: one stall, then forward from WB register.
    set_id(1, 1, 1, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 2, 1, 0, 1, 1, 1, 1);
    #2 check("ld1_stall", 32'(st[0]), 32'd1);
    check("ld1_bubble", 32'(bub[0]), 32'd1);
    tick();
    #2 check("ld1_release", 32'(st[0]), 32'd0);
    tick();
    idle();
    #2 check("ld1_fwd_a", 32'(fa[0]), 32'd2);
    check("ld1_fwd_b", 32'(fb[0]), 32'd2);
    drain();

    // NB=4, LOAD_LAT=2: two stalls, forward from slot 4.
    set_id(1, 5, 1, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 6, 1, 0, 5, 1, 0, 1);
    #2 check("ld2_stall_1", 32'(st[1]), 32'd1);
    tick();
    #2 check("ld2_stall_2", 32'(st[1]), 32'd1);
    tick();
    #2 check("ld2_release", 32'(st[1]), 32'd0);
    tick();
    idle();
    #2 check("ld2_fwd_a", 32'(fa[1]), 32'd3);
    check("ld2_fwd_b", 32'(fb[1]), 32'd0);
    drain();

    // x0 is never tracked; youngest of two writers wins.
    set_id(1, 0, 1, 0, 1, 1, 2, 1);
    tick();
    set_id(1, 4, 1, 0, 0, 1, 0, 1);
    #2 check("x0_stall", 32'(st[0]), 32'd0);
    tick();
    idle();
    #2 check("x0_fwd_a", 32'(fa[0]), 32'd0);
    check("x0_fwd_b", 32'(fb[0]), 32'd0);
    check("x0_cnt",   32'(cnt[0]), 32'd1);
    set_id(1, 7, 1, 0, 1, 1, 2, 1);
    tick();
    tick();
    set_id(1, 8, 1, 0, 7, 1, 0, 0);
    tick();
    idle();
    #2 check("youngest_fwd_a0", 32'(fa[0]), 32'd1);
    check("youngest_fwd_a1", 32'(fa[1]), 32'd1);
    check("youngest_cnt",    32'(cnt[0]), 32'd3);
    drain();

    // Redirect beats the load-use hazard.
    set_id(1, 1, 1, 1, 0, 0, 0, 0);
    tick();
    set_id(1, 2, 1, 0, 1, 1, 0, 0);
    ex_redirect = 1'b1;
    #2 check("redir_flush",  32'(fl[0]),  32'd1);
    check("redir_bubble", 32'(bub[0]), 32'd1);
    check("redir_stall",  32'(st[0]),  32'd0);
    tick();
    ex_redirect = 1'b0;
    drain();

    // Freeze holds forwarding state; reset mid-freeze clears everything.
    set_id(1, 9, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 10, 1, 0, 9, 1, 0, 0);
    tick();
    idle();
    mem_wait = 1'b1;
    #2 check("frz1_freeze", 32'(fz[0]),  32'd1);
    check("frz1_stall",  32'(st[0]),  32'd1);
    check("frz1_bubble", 32'(bub[0]), 32'd0);
    check("frz1_fwd_a",  32'(fa[0]),  32'd1);
    check("frz1_cnt",    32'(cnt[0]), 32'd2);
    tick();
    #2 check("frz2_freeze", 32'(fz[0]),  32'd1);
    check("frz2_fwd_a",  32'(fa[0]),  32'd1);
    check("frz2_cnt",    32'(cnt[0]), 32'd2);
    #1 reset = 1'b1;
    #2 check("frz_rst_freeze", 32'(fz[0]),  32'd0);
    check("frz_rst_stall",  32'(st[0]),  32'd0);
    check("frz_rst_fwd_a",  32'(fa[0]),  32'd0);
    check("frz_rst_cnt",    32'(cnt[0]), 32'd0);
    tick();
    tick();
    reset    = 1'b0;
    mem_wait = 1'b0;
    #2 check("post_rst_stall", 32'(st[0]),  32'd0);
    check("post_rst_cnt",   32'(cnt[1]), 32'd0);
    tick();

    // Randomized traffic with small register range for frequent matches.
    for (int c = 0; c < 1500; c++) begin
      reset       = ($urandom_range(0, 399) == 0);
      mem_wait    = ($urandom_range(0, 6) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1) != 0);
      tick();
    end

    reset       = 1'b0;
    mem_wait    = 1'b0;
    ex_redirect = 1'b0;
    idle();
    tick();
    compare_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
